channel_mixer: RTL and testbench



---
 rtl/channel_mixer.sv | 167 ++++++++++++++++
 tb/tb_channel_mixer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/channel_mixer.sv
// channel_mixer: accumulates routed channel samples into NUM_OUTPUTS buses
// per frame, then emits saturated results with per-bus clip flags.

// Per-bus accumulator with saturating output register.
module channel_mixer_lane #(
  parameter int ACC_WIDTH = 22,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clr_i,
  input  logic                        add_i,
  input  logic                        load_i,
  input  logic signed [ACC_WIDTH-1:0] sample_i,
  output logic        [OUT_WIDTH-1:0] out_o,
  output logic                        clip_o
);
  localparam logic signed [ACC_WIDTH-1:0] MAXV =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MINV = ~MAXV;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic        [OUT_WIDTH-1:0] out_q, sat_out;
  logic                        clip_q, sat_clip;

  // Clear wins over add; clear covers both frame abort and emit exit.
  always_comb begin
    acc_d = acc_q;
    if (clr_i)      acc_d = '0;
    else if (add_i) acc_d = acc_q + sample_i;
  end

  // Saturate the accumulator into the output range.
  always_comb begin
    sat_out  = acc_q[OUT_WIDTH-1:0];
    sat_clip = 1'b0;
    if (acc_q > MAXV) begin
      sat_out  = MAXV[OUT_WIDTH-1:0];
      sat_clip = 1'b1;
    end else if (acc_q < MINV) begin
      sat_out  = MINV[OUT_WIDTH-1:0];
      sat_clip = 1'b1;
    end
  end

  // Accumulator and held output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      out_q  <= '0;
      clip_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (load_i) begin
        out_q  <= sat_out;
        clip_q <= sat_clip;
      end
    end
  end

  assign out_o  = out_q;
  assign clip_o = clip_q;
endmodule

module channel_mixer #(
  parameter int IN_WIDTH     = 16,
  parameter int OUT_WIDTH    = 16,
  parameter int NUM_OUTPUTS  = 4,
  parameter int MAX_CHANNELS = 18
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             sample_clk_en,
  input  logic                             ch_valid,
  output logic                             ch_ready,
  input  logic [IN_WIDTH-1:0]              ch_sample,
  input  logic [NUM_OUTPUTS-1:0]           ch_route,
  input  logic                             ch_last,
  output logic                             out_valid,
  output logic [NUM_OUTPUTS*OUT_WIDTH-1:0] out_sample,
  output logic [NUM_OUTPUTS-1:0]           out_clip,
  output logic                             frame_err,
  input  logic                             frame_err_clr
);
  localparam int ACC_WIDTH = IN_WIDTH + $clog2(MAX_CHANNELS) + 1;
  localparam int CNT_W     = $clog2(MAX_CHANNELS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CHANNELS);

  typedef enum logic {ACCUM = 1'b0, EMIT = 1'b1} state_e;

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, frame_err_q, frame_err_d;
  logic             accept, ovf, add, clr, emit_exit;
  logic signed [ACC_WIDTH-1:0]            sample_ext;
  logic [NUM_OUTPUTS-1:0][OUT_WIDTH-1:0]  lane_out;

  // A frame-start strobe discards any sample offered in the same cycle.
  assign accept     = ch_valid && ch_ready && !sample_clk_en;
  assign ovf        = (cnt_q == CNT_MAX);
  assign add        = accept && !ovf;
  assign clr        = sample_clk_en || emit_exit;
  assign sample_ext = {{(ACC_WIDTH-IN_WIDTH){ch_sample[IN_WIDTH-1]}}, ch_sample};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ACCUM;
    else          state_q <= state_d;
  end

  // Next-state: frame-start strobe overrides everything, EMIT lasts one cycle.
  always_comb begin
    state_d = state_q;
    if (sample_clk_en)                    state_d = ACCUM;
    else if (state_q == ACCUM && accept && ch_last) state_d = EMIT;
    else if (state_q == EMIT)             state_d = ACCUM;
  end

  // FSM outputs.
  always_comb begin
    ch_ready  = (state_q == ACCUM);
    emit_exit = (state_q == EMIT) && !sample_clk_en;
  end

  // Channel counter saturates at MAX_CHANNELS; sticky error with set priority.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (add) cnt_d = cnt_q + CNT_W'(1);
    frame_err_d = frame_err_q;
    if (accept && ovf)      frame_err_d = 1'b1;
    else if (frame_err_clr) frame_err_d = 1'b0;
  end

  // Counter, error flag and output strobe registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
      out_valid_q <= emit_exit;
    end
  end

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_lane
    channel_mixer_lane #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr_i    (clr),
      .add_i    (add && ch_route[k]),
      .load_i   (emit_exit),
      .sample_i (sample_ext),
      .out_o    (lane_out[k]),
      .clip_o   (out_clip[k])
    );
  end

  assign out_sample = lane_out;
  assign out_valid  = out_valid_q;
  assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_channel_mixer.sv
// Directed bench for channel_mixer at default parameters.
module tb_channel_mixer;
  logic        clk = 1'b0;
  logic        reset_n, sample_clk_en, ch_valid, ch_last, frame_err_clr;
  logic        ch_ready, out_valid, frame_err;
  logic [15:0] ch_sample;
  logic [3:0]  ch_route, out_clip;
  logic [63:0] out_sample;

  int checks = 0, failures = 0, stalls = 0, nvld = 0;
  logic [15:0] vq [4];

  channel_mixer u_dut (
    .clk(clk), .reset_n(reset_n), .sample_clk_en(sample_clk_en),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_sample(ch_sample),
    .ch_route(ch_route), .ch_last(ch_last), .out_valid(out_valid),
    .out_sample(out_sample), .out_clip(out_clip), .frame_err(frame_err),
    .frame_err_clr(frame_err_clr)
  );

  always #5 clk = ~clk;

  // Record every out_valid cycle and the bus0 value presented with it.
  always @(negedge clk) begin
    if (out_valid) begin
      if (nvld < 4) vq[nvld] = out_sample[15:0];
      nvld = nvld + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Offer one sample and hold it until accepted.
  task automatic send(input logic [15:0] s, input logic [3:0] r, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    ch_valid = 1'b1; ch_sample = s; ch_route = r; ch_last = l;
    while (!ch_ready && n < 10) begin
      n++;
      @(negedge clk);
    end
    stalls += n;
    if (n >= 10) chk("rdy_timeout", 64'd0, 64'd1);
    @(posedge clk);
  endtask

  // After the last handshake: EMIT cycle, then the single out_valid cycle.
  task automatic finish_frame(input string tag, input logic [63:0] eo, input logic [3:0] ec);
    @(negedge clk);
    ch_valid = 1'b0; ch_last = 1'b0;
    chk({tag, "_emit_rdy"}, 64'(ch_ready), 64'd0);
    chk({tag, "_early_vld"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk({tag, "_out"}, out_sample, eo);
    chk({tag, "_clip"}, 64'(out_clip), 64'(ec));
    @(negedge clk);
    chk({tag, "_vld_pulse"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int nv0;
    reset_n = 1'b0; sample_clk_en = 1'b0; ch_valid = 1'b0; ch_last = 1'b0;
    frame_err_clr = 1'b0; ch_sample = '0; ch_route = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_out", out_sample, 64'd0);
    chk("rst_clip", 64'(out_clip), 64'd0);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("rst_rdy", 64'(ch_ready), 64'd1);

    // 100 - 50 + 7 on bus0
    send(16'd100, 4'b0001, 1'b0);
    send(-16'sd50, 4'b0001, 1'b0);
    send(16'd7, 4'b0001, 1'b1);
    finish_frame("sum", 64'h0000_0000_0000_0039, 4'h0);

    // Positive and negative saturation on all buses
    for (int i = 0; i < 18; i++) send(16'h7fff, 4'hf, i == 17);
    finish_frame("satp", 64'h7fff_7fff_7fff_7fff, 4'hf);
    for (int i = 0; i < 18; i++) send(16'h8000, 4'hf, i == 17);
    finish_frame("satn", 64'h8000_8000_8000_8000, 4'hf);

    // Overrun: 19th sample dropped, error sticky until cleared
    for (int i = 0; i < 19; i++) send(16'd1, 4'b0010, i == 18);
    finish_frame("ovf", 64'h0000_0000_0012_0000, 4'h0);
    chk("ovf_err", 64'(frame_err), 64'd1);
    @(negedge clk); frame_err_clr = 1'b1;
    @(negedge clk); frame_err_clr = 1'b0;
    chk("err_clr", 64'(frame_err), 64'd0);

    // Set and clear in the same cycle leaves the error set
    for (int i = 0; i < 18; i++) send(16'd1, 4'b0010, 1'b0);
    @(negedge clk);
    ch_valid = 1'b1; ch_sample = 16'd1; ch_last = 1'b1; frame_err_clr = 1'b1;
    @(negedge clk);
    frame_err_clr = 1'b0; ch_valid = 1'b0; ch_last = 1'b0;
    chk("err_setclr", 64'(frame_err), 64'd1);
    @(negedge clk);
    chk("ovf2_out", out_sample, 64'h0000_0000_0012_0000);
    @(negedge clk); frame_err_clr = 1'b1;
    @(negedge clk); frame_err_clr = 1'b0;

    // Frame abort discards partial sum and the sample offered with the strobe
    nv0 = nvld;
    for (int i = 0; i < 5; i++) send(16'd1000, 4'b0100, 1'b0);
    @(negedge clk);
    ch_valid = 1'b1; ch_sample = 16'd1000; sample_clk_en = 1'b1;
    @(negedge clk);
    ch_valid = 1'b0; sample_clk_en = 1'b0;
    chk("abort_hold", out_sample, 64'h0000_0000_0012_0000);
    chk("abort_vld", 64'(out_valid), 64'd0);
    send(16'd10, 4'b0100, 1'b0);
    send(16'd10, 4'b0100, 1'b1);
    finish_frame("abort", 64'h0000_0014_0000_0000, 4'h0);
    chk("abort_npulse", 64'(nvld - nv0), 64'd1);

    // Strobe during EMIT cancels the emit
    nv0 = nvld;
    for (int i = 0; i < 3; i++) send(16'd1, 4'b0001, i == 2);
    @(negedge clk);
    ch_valid = 1'b0; ch_last = 1'b0; sample_clk_en = 1'b1;
    @(negedge clk);
    sample_clk_en = 1'b0;
    chk("cancel_vld", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("cancel_hold", out_sample, 64'h0000_0014_0000_0000);
    chk("cancel_npulse", 64'(nvld - nv0), 64'd0);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 4; i++) send(16'd500, 4'hf, 1'b0);
    @(negedge clk);
    ch_valid = 1'b0; reset_n = 1'b0;
    #1;
    chk("arst_out", out_sample, 64'd0);
    chk("arst_vld", 64'(out_valid), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    send(16'd5, 4'b1000, 1'b1);
    finish_frame("arst", 64'h0005_0000_0000_0000, 4'h0);

    // Only unrouted samples: all-zero result
    send(16'd1234, 4'b0000, 1'b0);
    send(16'h8000, 4'b0000, 1'b1);
    finish_frame("zero", 64'd0, 4'h0);

    // Back-to-back frames with valid held high
    nv0 = nvld; stalls = 0;
    send(16'd1, 4'b0001, 1'b0);
    send(16'd1, 4'b0001, 1'b0);
    send(16'd1, 4'b0001, 1'b1);
    send(16'd2, 4'b0001, 1'b0);
    send(16'd2, 4'b0001, 1'b1);
    @(negedge clk);
    ch_valid = 1'b0; ch_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_stalls", 64'(stalls), 64'd1);
    chk("b2b_npulse", 64'(nvld - nv0), 64'd2);
    if (nvld - nv0 == 2 && nv0 + 1 < 4) begin
      chk("b2b_f0", 64'(vq[nv0]), 64'd3);
      chk("b2b_f1", 64'(vq[nv0+1]), 64'd4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
